// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//
// Block-copy initiator for the 16-bit datapath. On a start request it copies
// len consecutive words from the source range to the destination range. Each
// word is read, then written, before the next word is read. While busy is
// high, this block owns the address, write-data and write-enable side of the
// synchronous main memory.
//
// Ports:
//   clk        clock; every state change happens on the rising edge
//   reset      asynchronous, active-high; forces IDLE and all outputs to 0
//   start      copy request, sampled only in IDLE
//   src        first source address, sampled with start
//   dst        first destination address, sampled with start
//   len        word count, sampled with start (0 gives an immediate done)
//   busy       copy in progress
//   done       one-cycle completion pulse
//   remaining  words not yet written
//   mem_addr   memory address (registered)
//   mem_wdata  memory write data (registered)
//   mem_we     memory write enable (registered; high only in WR)
//   mem_rdata  memory read data, valid the cycle after a read address

module mem_copy_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] remaining,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Each word takes three cycles: present the read address, let the
    // registered read data arrive, then present the write.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge value of state, pointers and remaining.
            done <= 1'b0;  // done is a pulse; only the two completion paths raise it
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state     <= ST_RD;
                            src_ptr   <= src;
                            dst_ptr   <= dst;
                            remaining <= len;
                            busy      <= 1'b1;
                            mem_addr  <= src;
                            mem_we    <= 1'b0;
                        end else begin
                            // Zero-length copy: acknowledge without touching memory.
                            done <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Read data for src_ptr is valid in this cycle.
                    state     <= ST_WR;
                    mem_wdata <= mem_rdata;
                    mem_addr  <= dst_ptr;
                    mem_we    <= 1'b1;
                end

                ST_WR: begin
                    mem_we <= 1'b0;
                    if (remaining > ADDR_WIDTH'(1)) begin
                        state     <= ST_RD;
                        src_ptr   <= src_ptr + ADDR_WIDTH'(1);
                        dst_ptr   <= dst_ptr + ADDR_WIDTH'(1);
                        mem_addr  <= src_ptr + ADDR_WIDTH'(1);
                        remaining <= remaining - ADDR_WIDTH'(1);
                    end else begin
                        state     <= ST_IDLE;
                        remaining <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
